// File: rtl/pipelined_adder_pkg.sv
// ============================================================================
// pipelined_adder_pkg : shared defaults and result-flag record
// Revision 1.0
// ============================================================================
`default_nettype none

package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 2;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
    } result_flags_t;

endpackage

`default_nettype wire

// File: rtl/adder_slice.sv
// ============================================================================
// adder_slice : CHUNK-bit adder with carry in/out and MSB carry-in tap
// Revision 1.0
// ============================================================================
`default_nettype none

module adder_slice #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] full;

    assign full    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum     = full[CHUNK-1:0];
    assign cout    = full[CHUNK];
    // The carry entering the top bit is recovered from that bit's sum and operands.
    assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
// pipelined_adder : valid/ready pipelined add/subtract, one slice per stage
// Revision 1.0
// ============================================================================
`default_nettype none

module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] stage_valid;
    result_flags_t     flags;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] acc_in;
        logic [WIDTH-1:0] b_in;
        logic             cin_in;
        logic             valid_in;
        logic [CHUNK-1:0] slice_sum;
        logic             slice_cout;
        logic             slice_msb;
        logic             ready;
        logic             valid_q;
        logic [WIDTH-1:0] acc_q;
        logic             carry_q;

        // A stage can take new data unless it and every stage after it is full and stalled.
        assign ready          = out_ready || !(&stage_valid[STAGES-1:k]);
        assign stage_valid[k] = valid_q;

        if (k == 0) begin : g_src
            assign acc_in   = in_a;
            assign b_in     = in_sub ? ~in_b : in_b;
            assign cin_in   = in_sub | in_cin;
            assign valid_in = in_valid;
        end else begin : g_chain
            assign acc_in   = g_stage[k-1].acc_q;
            assign b_in     = g_stage[k-1].g_fwd.b_q;
            assign cin_in   = g_stage[k-1].carry_q;
            assign valid_in = g_stage[k-1].valid_q;
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a       (acc_in[CHUNK-1:0]),
            .b       (b_in[CHUNK-1:0]),
            .cin     (cin_in),
            .sum     (slice_sum),
            .cout    (slice_cout),
            .msb_cin (slice_msb)
        );

        // acc rotates right one slice per stage: finished sum slices enter at the top,
        // unprocessed operand-a slices move down, so after STAGES hops it is the sum.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                acc_q   <= '0;
                carry_q <= 1'b0;
            end else if (ready) begin
                valid_q <= valid_in;
                acc_q   <= (acc_in >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
                carry_q <= slice_cout;
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic             ovf_q;
            logic [WIDTH-1:0] unused_b;

            assign unused_b = b_in;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (ready) begin
                    ovf_q <= slice_cout ^ slice_msb;
                end
            end
        end else begin : g_fwd
            logic [WIDTH-1:0] b_q;
            logic             unused_msb;

            assign unused_msb = slice_msb;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (ready) begin
                    b_q <= (b_in >> CHUNK) | (b_in << (WIDTH - CHUNK));
                end
            end
        end
    end

    assign in_ready    = g_stage[0].ready;
    assign out_valid   = stage_valid[STAGES-1];
    assign out_sum     = g_stage[STAGES-1].acc_q;

    assign flags.carry = g_stage[STAGES-1].carry_q;
    assign flags.ovf   = g_stage[STAGES-1].g_last.ovf_q;
    assign flags.zero  = out_valid && (out_sum == '0);

    assign out_carry   = flags.carry;
    assign out_ovf     = flags.ovf;
    assign out_zero    = flags.zero;

endmodule

`default_nettype wire

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8..64).
REQ-002 SHALL have parameter STAGES, default 2, number of register stages (legal: 1..4; WIDTH divisible by STAGES).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand set on in_* is valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-007 SHALL have port in_a  input  WIDTH  first operand.
REQ-008 SHALL have port in_b  input  WIDTH  second operand.
REQ-009 SHALL have port in_sub  input  1  0 = add, 1 = subtract (a - b).
REQ-010 SHALL have port in_cin  input  1  carry-in, used only when in_sub = 0.
REQ-011 SHALL have port out_valid  output  1  result on out_* is valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-013 SHALL have port out_sum  output  WIDTH  result.
REQ-014 SHALL have port out_carry  output  1  unsigned carry-out of the MSB (for subtract: 1 = no borrow).
REQ-015 SHALL have port out_ovf  output  1  signed two's-complement overflow.
REQ-016 SHALL have port out_zero  output  1  out_sum equals zero.

Function
REQ-017 Transfer on input SHALL occur when in_valid and in_ready are both 1; on output when out_valid and out_ready are both 1.
REQ-018 Add SHALL compute a + b + in_cin; subtract SHALL compute a + ~b + 1, ignoring in_cin.
REQ-019 Operation SHALL be split into STAGES slices of CHUNK = WIDTH/STAGES bits; stage k adds slice k using the carry registered by stage k-1.
REQ-020 Unprocessed upper operand slices and already-computed lower sum slices SHALL travel with their transaction through the stage registers.
REQ-021 out_carry SHALL be the carry out of bit WIDTH-1; out_ovf SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-022 out_zero SHALL be derived from the final registered out_sum, with no extra latency.
REQ-023 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, when out_ready is held 1.
REQ-024 Throughput SHALL be one transaction per cycle while out_ready = 1.
REQ-025 Each stage SHALL hold a valid bit; a stage loads when it is empty or its contents move forward in the same cycle.
REQ-026 in_ready SHALL be 1 when stage 0 is empty or stage 0 advances this cycle; in_ready SHALL NOT depend on in_valid.
REQ-027 With out_ready = 0 the pipeline SHALL fill to STAGES entries, then deassert in_ready; no transaction is lost or duplicated.
REQ-028 Results SHALL emerge in acceptance order.
REQ-029 out_* data SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-030 Simultaneous input and output transfers on a full pipeline SHALL both complete in the same cycle.
REQ-031 Arithmetic SHALL wrap modulo 2^WIDTH; overflow is flagged and never saturated.

Reset
REQ-032 While rst_n = 0 at a rising clk edge, every stage valid bit SHALL clear.
REQ-033 After that edge, out_valid SHALL be 0, and out_sum, out_carry, out_ovf and out_zero SHALL be 0.
REQ-034 Reset mid-operation SHALL discard all in-flight transactions; in_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Structure
REQ-035 Shared package pipelined_adder_pkg SHALL hold DEFAULT_WIDTH, DEFAULT_STAGES and the result-flag record (carry, ovf, zero).
REQ-036 One sub-module, adder_slice, SHALL implement a CHUNK-bit add with carry-in and carry-out plus the MSB carry-in tap used for overflow.
REQ-037 adder_slice SHALL be instantiated STAGES times; stage registers and handshake SHALL live in pipelined_adder.

Verification
REQ-038 WIDTH=32, STAGES=2: add 0x7FFFFFFF + 0x00000001 -> after 2 cycles out_sum=0x80000000, out_ovf=1, out_carry=0, out_zero=0.
REQ-039 Add 0xFFFFFFFF + 0x00000001, cin=0 -> out_sum=0x00000000, out_carry=1, out_zero=1, out_ovf=0.
REQ-040 Subtract 5 - 7 -> 0xFFFFFFFE, out_carry=0, out_ovf=0; subtract 0x80000000 - 1 -> 0x7FFFFFFF, out_ovf=1, out_carry=1.
REQ-041 Back-to-back inputs 1+1, 2+2, 3+3, 4+4 with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts; after release, outputs 2, 4, 6, 8 appear in order with no loss.
REQ-042 Pipeline full, rst_n=0 for one cycle -> next cycle out_valid=0 and in_ready=1; no stale result ever appears.
REQ-043 WIDTH=8, STAGES=1: add 0x80 + 0x80 -> out_sum=0x00, out_carry=1, out_ovf=1, out_zero=1, latency 1 cycle.
